and_stim_checker: RTL and testbench

AND_STIM_CHECKER -- requirements
Module: and_stim_checker

---
 rtl/and_test_pkg.sv | 23 ++
 rtl/settle_timer.sv | 28 ++
 rtl/and_stim_checker.sv | 114 +++++++++++
 tb/tb_and_stim_checker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/and_test_pkg.sv
// Shared types and constants for the AND-gate stimulus checker.
// FSM states, vector width and error counter limits.
package and_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int VEC_W = 2;
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

    function automatic logic [ERR_W-1:0] sat_inc(
        input logic [ERR_W-1:0] v
    );
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expire pulses in the last
// counted cycle so the caller holds for exactly 'cycles'.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] cycles,
    output logic         expire
);

    logic [W-1:0] cnt;

    // load the hold length, then count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= cycles;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/and_stim_checker.sv
// Sweeps all four input vectors through an external AND gate
// and counts mismatches against the locally computed AND.
module and_stim_checker
    import and_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int SWEEPS        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             input1,
    output logic             input2,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] vector_idx
);

    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYCLES);
    localparam logic [7:0] LAST_SWEEP = 8'(SWEEPS - 1);

    state_t           state;
    logic [7:0]       sweep_cnt;
    logic             expire;
    logic             expected;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;
    logic [VEC_W-1:0] idx_inc;

    assign expected = input1 & input2;
    assign mismatch = (dut_out != expected);
    assign err_next = mismatch ? sat_inc(err_count) : err_count;
    assign idx_inc  = vector_idx + 2'd1;

    settle_timer #(
        .W(4)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == APPLY),
        .cycles (SETTLE_LD),
        .expire (expire)
    );

    // run sequencer: apply, settle, sample each vector per sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            input1     <= 1'b0;
            input2     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vector_idx <= '0;
            sweep_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= APPLY;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        vector_idx <= '0;
                        sweep_cnt  <= '0;
                        input1     <= 1'b0;
                        input2     <= 1'b0;
                    end
                end
                APPLY: begin
                    input1 <= vector_idx[1];
                    input2 <= vector_idx[0];
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_count <= err_next;
                    if (vector_idx != 2'd3) begin
                        vector_idx <= idx_inc;
                        input1     <= idx_inc[1];
                        input2     <= idx_inc[0];
                        state      <= APPLY;
                    end else if (sweep_cnt < LAST_SWEEP) begin
                        vector_idx <= '0;
                        input1     <= 1'b0;
                        input2     <= 1'b0;
                        sweep_cnt  <= sweep_cnt + 8'd1;
                        state      <= APPLY;
                    end else begin
                        input1 <= 1'b0;
                        input2 <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pass   <= (err_next == '0);
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_stim_checker.sv
// Directed + randomized bench for and_stim_checker.
// Gate under test is a truth table; a run-level model predicts results.
module tb_and_stim_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic [3:0] tt = 4'b1000;

    always #5 clk = ~clk;

    logic a_start, a_i1, a_i2, a_dut, a_busy, a_done, a_pass;
    logic b_start, b_i1, b_i2, b_dut, b_busy, b_done, b_pass;
    logic [7:0] a_err, b_err;
    logic [1:0] a_idx, b_idx;

    logic i1, i2, busy, done, pass;
    logic [7:0] err;
    logic [1:0] idx;

    assign a_start = start & ~sel;
    assign b_start = start & sel;
    assign a_dut   = tt[{a_i1, a_i2}];
    assign b_dut   = tt[{b_i1, b_i2}];

    assign i1   = sel ? b_i1 : a_i1;
    assign i2   = sel ? b_i2 : a_i2;
    assign busy = sel ? b_busy : a_busy;
    assign done = sel ? b_done : a_done;
    assign pass = sel ? b_pass : a_pass;
    assign err  = sel ? b_err : a_err;
    assign idx  = sel ? b_idx : a_idx;

    and_stim_checker #(
        .SETTLE_CYCLES(2),
        .SWEEPS(1)
    ) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (a_start),
        .input1     (a_i1),
        .input2     (a_i2),
        .dut_out    (a_dut),
        .busy       (a_busy),
        .done       (a_done),
        .pass       (a_pass),
        .err_count  (a_err),
        .vector_idx (a_idx)
    );

    and_stim_checker #(
        .SETTLE_CYCLES(1),
        .SWEEPS(255)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .input1     (b_i1),
        .input2     (b_i2),
        .dut_out    (b_dut),
        .busy       (b_busy),
        .done       (b_done),
        .pass       (b_pass),
        .err_count  (b_err),
        .vector_idx (b_idx)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // mismatches a whole run should record, saturated at 255
    function automatic int model_err(input int sw,
                                     input logic [3:0] t);
        int bad = 0;
        for (int v = 0; v < 4; v++) begin
            if (t[v] != (v == 3)) bad++;
        end
        bad = bad * sw;
        return (bad > 255) ? 255 : bad;
    endfunction

    task automatic do_run(input int s, input int sw,
                          input logic [3:0] t,
                          input bit glitch);
        int len;
        int e;
        int v;
        len = 4 * sw * (s + 2);
        e = model_err(sw, t);
        tt = t;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            start = 1'b0;
            v = (k / (s + 2)) % 4;
            chk("busy", 32'(busy), 1);
            chk("done_early", 32'(done), 0);
            chk("idx", 32'(idx), 32'(v));
            chk("stim", 32'({i1, i2}), 32'(v));
            if (k == 0) chk("err_clr", 32'(err), 0);
            if (glitch && (k == 3 || k == 9)) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done", 32'(done), 1);
        chk("busy_done", 32'(busy), 0);
        chk("err", 32'(err), 32'(e));
        chk("pass", 32'(pass), 32'(e == 0));
        chk("stim_done", 32'({i1, i2}), 0);
        repeat (2) @(negedge clk);
        chk("done_held", 32'(done), 1);
        chk("err_held", 32'(err), 32'(e));
    endtask

    initial begin
        logic [3:0] rt;

        // reset state of both instances
        #1;
        chk("rst_a", 32'({a_i1, a_i2, a_busy, a_done,
                          a_pass, a_err, a_idx}), 0);
        chk("rst_b", 32'({b_i1, b_i2, b_busy, b_done,
                          b_pass, b_err, b_idx}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(a_busy), 0);
        chk("idle_done", 32'(a_done), 0);

        // correct AND gate, stuck-at-1, restart with ignored starts
        sel = 1'b0;
        do_run(2, 1, 4'b1000, 1'b0);
        do_run(2, 1, 4'b1111, 1'b0);
        do_run(2, 1, 4'b1000, 1'b1);
        do_run(2, 1, 4'b1110, 1'b1);

        // reset pulsed in the middle of a run
        tt = 4'b0111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", 32'(a_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst", 32'({a_i1, a_i2, a_busy, a_done,
                            a_pass, a_err, a_idx}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_done", 32'(a_done), 0);
        chk("post_rst_busy", 32'(a_busy), 0);
        chk("post_rst_err", 32'(a_err), 0);
        do_run(2, 1, 4'b1000, 1'b0);

        // randomized truth tables on the default instance
        for (int r = 0; r < 6; r++) begin
            rt = 4'($urandom);
            do_run(2, 1, rt, 1'($urandom));
        end

        // long sweeps: saturation and vector wrap
        sel = 1'b1;
        do_run(1, 255, 4'b0111, 1'b0);
        do_run(1, 255, 4'b1000, 1'b1);
        rt = 4'($urandom);
        do_run(1, 255, rt, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
